apb_byte_requester: RTL and testbench

- Byte-stream-to-APB initiator. It accepts command bytes on a valid/ready input stream and issues single APB read or write transfers to the 5-bit-address, 8-bit-data APB bus used by the debugger and reflector completers.
- It returns one response byte per command on a valid/ready output stream.
- Any serial front end (UART, SPI, test bench) can drive the completers through it. The block has a PREADY timeout so a hung completer cannot lock the bus.

---
 rtl/apb_byte_requester.sv | 133 +++++++++++++
 tb/tb_apb_byte_requester.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/apb_byte_requester.sv
// Byte-stream to APB initiator: one command (header plus optional data byte)
// becomes one APB transfer and one response byte, with a PREADY timeout.
module apb_byte_requester #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned TIMEOUT  = 15,
  parameter logic [7:0]  WR_ACK   = 8'hA5,
  parameter logic [7:0]  ERR_BYTE = 8'hEE
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [7:0]        rsp_data,
  output logic              PSEL,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [7:0]        PWDATA,
  input  logic [7:0]        PRDATA,
  input  logic              PREADY,
  output logic              busy
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, GET_DATA, SETUP, ACCESS, RESP
  } state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic                psel_n, penable_n, pwrite_n, rsp_valid_n;
  logic [ADDR_W-1:0]   paddr_n;
  logic [7:0]          pwdata_n, rsp_data_n;

  assign cmd_ready = (state == IDLE) || (state == GET_DATA);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      cnt       <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      PSEL      <= psel_n;
      PENABLE   <= penable_n;
      PWRITE    <= pwrite_n;
      PADDR     <= paddr_n;
      PWDATA    <= pwdata_n;
      rsp_valid <= rsp_valid_n;
      rsp_data  <= rsp_data_n;
      busy      <= (state_n != IDLE);
    end
  end

  // Outputs are registered, so each APB/response output is set on the edge
  // that enters the state in which it must be visible.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    psel_n      = PSEL;
    penable_n   = PENABLE;
    pwrite_n    = PWRITE;
    paddr_n     = PADDR;
    pwdata_n    = PWDATA;
    rsp_valid_n = rsp_valid;
    rsp_data_n  = rsp_data;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          paddr_n  = cmd_data[ADDR_W-1:0];
          pwrite_n = cmd_data[7];
          if (cmd_data[7]) begin
            state_n = GET_DATA;
          end else begin
            state_n = SETUP;
            psel_n  = 1'b1;
          end
        end
      end
      GET_DATA: begin
        if (cmd_valid) begin
          pwdata_n = cmd_data;
          state_n  = SETUP;
          psel_n   = 1'b1;
        end
      end
      SETUP: begin
        state_n   = ACCESS;
        penable_n = 1'b1;
      end
      ACCESS: begin
        if (PREADY) begin
          psel_n      = 1'b0;
          penable_n   = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_data_n  = PWRITE ? WR_ACK : PRDATA;
          cnt_n       = '0;
          state_n     = RESP;
        end else if ((TIMEOUT != 0) && (cnt == LIMIT)) begin
          psel_n      = 1'b0;
          penable_n   = 1'b0;
          rsp_valid_n = 1'b1;
          rsp_data_n  = ERR_BYTE;
          cnt_n       = '0;
          state_n     = RESP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_apb_byte_requester.sv
// Self-checking bench for apb_byte_requester: directed and random commands
// against a transaction-level expectation of response, timing and bus shape.
module tb_apb_byte_requester;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_data = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       PSEL;
  logic [4:0] PADDR;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA = '0;
  logic       PREADY = 1'b0;
  logic       busy;

  int unsigned checks = 0;
  int unsigned failures = 0;

  apb_byte_requester #(
    .ADDR_W  (5),
    .TIMEOUT (15),
    .WR_ACK  (8'hA5),
    .ERR_BYTE(8'hEE)
  ) dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_data (cmd_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .PSEL     (PSEL),
    .PADDR    (PADDR),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .busy     (busy)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full command: waits = ACCESS cycles with PREADY low before it rises,
  // gap = idle cycles between write header and data, bp = rsp_ready-low cycles.
  task automatic run_txn(input logic w, input logic [4:0] addr, input logic [7:0] wdata,
                         input int unsigned waits, input logic [7:0] prdata,
                         input int unsigned gap, input int unsigned bp);
    int unsigned exp_acc, cyc, setups, acc;
    logic [7:0] exp_rsp, held;
    logic done;
    exp_acc = (waits >= 15) ? 15 : waits + 1;
    exp_rsp = (waits >= 15) ? 8'hEE : (w ? 8'hA5 : prdata);

    chk("idle_cmd_ready", cmd_ready, 1'b1);
    chk("idle_busy", busy, 1'b0);
    cmd_valid = 1'b1;
    cmd_data  = {w, 2'($urandom), addr};
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    if (w) begin
      for (int i = 0; i < int'(gap); i++) begin
        @(negedge PCLK);
        chk("gap_busy", busy, 1'b1);
        chk("gap_cmd_ready", cmd_ready, 1'b1);
        chk("gap_psel", PSEL, 1'b0);
      end
      cmd_valid = 1'b1;
      cmd_data  = wdata;
      @(posedge PCLK); #1;
      cmd_valid = 1'b0;
    end

    cyc = 0; setups = 0; acc = 0; done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge PCLK);
      cyc++;
      if (PENABLE && !PSEL) chk("penable_wo_psel", PSEL, 1'b1);
      if (PSEL) begin
        chk("paddr", PADDR, addr);
        chk("pwrite", PWRITE, w);
        if (w) chk("pwdata", PWDATA, wdata);
        chk("busy_xfer", busy, 1'b1);
        if (PENABLE) begin
          acc++;
          PREADY = (acc > waits);
          PRDATA = prdata;
        end else begin
          setups++;
        end
      end else begin
        done = 1'b1;
      end
    end
    PREADY = 1'b0;
    chk("xfer_finished", done, 1'b1);
    chk("setup_cycles", setups, 1);
    chk("access_cycles", acc, exp_acc);
    chk("rsp_latency", cyc, exp_acc + 2);
    chk("rsp_valid", rsp_valid, 1'b1);
    chk("rsp_data", rsp_data, exp_rsp);

    held = rsp_data;
    cmd_valid = 1'b1;
    cmd_data  = 8'h0F;
    for (int i = 0; i < int'(bp); i++) begin
      @(negedge PCLK);
      chk("bp_rsp_valid", rsp_valid, 1'b1);
      chk("bp_rsp_data", rsp_data, held);
      chk("bp_cmd_ready", cmd_ready, 1'b0);
      chk("bp_psel", PSEL, 1'b0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    chk("post_rsp_valid", rsp_valid, 1'b0);
    chk("post_cmd_ready", cmd_ready, 1'b1);
    chk("post_busy", busy, 1'b0);
    chk("post_psel", PSEL, 1'b0);
  endtask

  initial begin
    #3;
    chk("rst_psel", PSEL, 1'b0);
    chk("rst_penable", PENABLE, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_paddr", PADDR, 5'h00);
    chk("rst_rsp_data", rsp_data, 8'h00);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);

    run_txn(1'b0, 5'h07, 8'h00, 0, 8'h3C, 0, 0);   // zero-wait read
    run_txn(1'b1, 5'h12, 8'h5A, 0, 8'h00, 3, 0);   // write with header/data gap
    run_txn(1'b0, 5'h0B, 8'h00, 4, 8'hC3, 0, 0);   // 4 wait states
    run_txn(1'b1, 5'h1F, 8'h81, 4, 8'h00, 0, 1);
    run_txn(1'b0, 5'h03, 8'h00, 100, 8'h55, 0, 0); // stuck PREADY -> timeout
    run_txn(1'b0, 5'h03, 8'h00, 14, 8'h66, 0, 0);  // PREADY in 15th cycle
    run_txn(1'b1, 5'h04, 8'h77, 15, 8'h00, 1, 0);  // write timeout
    run_txn(1'b0, 5'h1A, 8'h00, 1, 8'h99, 0, 10);  // response backpressure

    for (int n = 0; n < 25; n++) begin
      run_txn(1'($urandom), 5'($urandom), 8'($urandom), $urandom_range(0, 18),
              8'($urandom), $urandom_range(0, 3), $urandom_range(0, 4));
    end

    // Asynchronous reset in the middle of ACCESS
    cmd_valid = 1'b1;
    cmd_data  = 8'h09;
    @(posedge PCLK); #1;
    cmd_valid = 1'b0;
    repeat (3) @(negedge PCLK);
    chk("pre_rst_penable", PENABLE, 1'b1);
    #2;
    PRESETn = 1'b0;
    #1;
    chk("arst_psel", PSEL, 1'b0);
    chk("arst_penable", PENABLE, 1'b0);
    chk("arst_rsp_valid", rsp_valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    @(negedge PCLK);
    #2;
    PRESETn = 1'b1;
    @(negedge PCLK);
    chk("after_rst_cmd_ready", cmd_ready, 1'b1);
    chk("after_rst_psel", PSEL, 1'b0);
    run_txn(1'b0, 5'h15, 8'h00, 2, 8'h42, 0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
